// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Divides the system clock into a pixel tick, runs the horizontal and
// vertical raster counters, and produces sync, display-enable, line/frame
// markers and a completed-frame count. Every output is a flop loaded from
// the next-state counter values, so sync and enable never skew against x/y.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11,
  parameter int FW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  // A divide-by-1 still needs a one-bit divider register to stay legal.
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic VS_ON  = (VS_POL != 0);

  logic [DW-1:0] div;
  logic          tick;
  logic          x_end;
  logic          y_end;
  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          de_nxt;
  logic          hs_nxt;
  logic          vs_nxt;

  assign tick  = en && (div == DW'(CLK_DIV - 1));
  assign x_end = (x == CW'(H_TOTAL - 1));
  assign y_end = (y == CW'(V_TOTAL - 1));

  // Next-state raster position: x steps on each tick, y steps on each x wrap.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (tick) begin
      x_nxt = x_end ? '0 : x + CW'(1);
      if (x_end) begin
        y_nxt = y_end ? '0 : y + CW'(1);
      end
    end
  end

  // Decode sync and enable from the next-state position so they land with x/y.
  always_comb begin
    de_nxt = (x_nxt < CW'(H_ACTIVE)) && (y_nxt < CW'(V_ACTIVE));
    hs_nxt = ((x_nxt >= CW'(HS_START)) && (x_nxt < CW'(HS_END))) ? HS_ON : ~HS_ON;
    vs_nxt = ((y_nxt >= CW'(VS_START)) && (y_nxt < CW'(VS_END))) ? VS_ON : ~VS_ON;
  end

  // Pixel divider: counts clocks within a pixel period, parked at 0 when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (!en) begin
      div <= '0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
    end
  end

  // Raster counters and their registered decodes; disabling parks at (0,0) idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x  <= '0;
      y  <= '0;
      de <= 1'b0;
      hs <= ~HS_ON;
      vs <= ~VS_ON;
    end else if (!en) begin
      x  <= '0;
      y  <= '0;
      de <= 1'b0;
      hs <= ~HS_ON;
      vs <= ~VS_ON;
    end else begin
      x  <= x_nxt;
      y  <= y_nxt;
      de <= de_nxt;
      hs <= hs_nxt;
      vs <= vs_nxt;
    end
  end

  // Pixel/line/frame pulses and the completed-frame count, which survives en=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (!en) begin
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      line_start  <= tick && x_end;
      frame_start <= tick && x_end && y_end;
      if (tick && x_end && y_end) begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen using a reduced raster
// (H 8/2/3/2 = 15 pixels, V 4/1/2/1 = 8 lines, divide-by-2, hs active-high,
// vs active-low, 4-bit frame counter) so full frames and the frame-count
// wrap fit in a short run. Expected values come from the clock count.
module tb_vga_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int HT      = 15;
  localparam int VT      = 8;
  localparam int FRAME   = HT * VT;

  logic        clk;
  logic        rst;
  logic        en;
  logic        hs;
  logic        vs;
  logic [10:0] x;
  logic [10:0] y;
  logic        de;
  logic        pix_tick;
  logic        line_start;
  logic        frame_start;
  logic [3:0]  frame_cnt;

  int checks;
  int errors;
  int fc_base;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(0),
    .CW(11), .FW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .hs(hs),
    .vs(vs),
    .x(x),
    .y(y),
    .de(de),
    .pix_tick(pix_tick),
    .line_start(line_start),
    .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  // Free-running 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic e);
    rst = r;
    en  = e;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Idle/reset-level outputs: parked at (0,0), no enable, sync inactive.
  task automatic checkIdle(input string tag, input int fc);
    checkOutput({tag, " x"}, int'(x), 0);
    checkOutput({tag, " y"}, int'(y), 0);
    checkOutput({tag, " de"}, int'(de), 0);
    checkOutput({tag, " hs"}, int'(hs), 0);
    checkOutput({tag, " vs"}, int'(vs), 1);
    checkOutput({tag, " pix_tick"}, int'(pix_tick), 0);
    checkOutput({tag, " line_start"}, int'(line_start), 0);
    checkOutput({tag, " frame_start"}, int'(frame_start), 0);
    checkOutput({tag, " frame_cnt"}, int'(frame_cnt), fc);
  endtask

  // Runs 'cycles' edges with en=1 from a parked raster, checking every clock.
  task automatic runCheck(input int cycles, input int fbase, output int fend);
    int ticks, ex, ey, efc;
    logic epix, eline;
    fend = fbase;
    for (int n = 1; n <= cycles; n++) begin
      @(posedge clk);
      @(negedge clk);
      ticks = n / CLK_DIV;
      ex    = ticks % HT;
      ey    = (ticks / HT) % VT;
      efc   = (fbase + ticks / FRAME) % 16;
      epix  = (n % CLK_DIV) == 0;
      eline = epix && (ex == 0);
      checkOutput("x", int'(x), ex);
      checkOutput("y", int'(y), ey);
      checkOutput("de", int'(de), int'(ex < 8 && ey < 4));
      checkOutput("hs", int'(hs), int'(ex >= 10 && ex <= 12));
      checkOutput("vs", int'(vs), int'(!(ey >= 5 && ey <= 6)));
      checkOutput("pix_tick", int'(pix_tick), int'(epix));
      checkOutput("line_start", int'(line_start), int'(eline));
      checkOutput("frame_start", int'(frame_start), int'(eline && ey == 0));
      checkOutput("frame_cnt", int'(frame_cnt), efc);
      fend = efc;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    fc_base = 0;

    // Hold reset and confirm the reset-state outputs.
    applyStimulus(1'b0, 1'b1);
    #23;
    checkIdle("reset", 0);

    // Release between edges; run past 16 frames so frame_cnt wraps to 0 and on.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    runCheck(4220, 0, fc_base);
    checkOutput("pre-disable frame_cnt", int'(frame_cnt), 1);
    checkOutput("pre-disable x", int'(x), 10);

    // Drop enable mid-frame for five clocks: parked raster, frame count held.
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkIdle("disabled", fc_base);
    end

    // Re-enable: counting restarts from (0,0) with no spurious frame_start.
    applyStimulus(1'b1, 1'b1);
    runCheck(300, fc_base, fc_base);
    checkOutput("restart frame_cnt", int'(frame_cnt), 2);

    // Assert reset between edges; outputs must clear before the next edge.
    @(posedge clk);
    #2;
    applyStimulus(1'b0, 1'b1);
    #1;
    checkIdle("async reset", 0);

    // Recover from reset and check the first few pixels again.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    runCheck(40, 0, fc_base);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
